// File: rtl/instruction_decoder.sv
// Fetch/decode stage: registers program-memory words into the IR, decodes jump control,
// tracks the zero flag and generates the core-wide synchronous reset.
module instruction_decoder #(
    parameter logic [3:0] JMP_OPC     = 4'hE,
    parameter logic [3:0] JNZ_OPC     = 4'hF,
    parameter logic [7:0] NOP_WORD    = 8'h00,
    parameter int         SYNC_STAGES = 2,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       pm_data,
    input  logic             alu_wr,
    input  logic             alu_zero,
    output logic             sync_reset,
    output logic [7:0]       ir,
    output logic             jmp,
    output logic             jmp_nz,
    output logic             dont_jmp,
    output logic [3:0]       jmp_addr,
    output logic [CNT_W-1:0] jmp_count
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [7:0]             ir_q, ir_d;
    logic                   z_q, z_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   taken;

    // Reset synchronizer: asserts asynchronously, releases after a zero shifts through.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign sync_reset = sync_q[SYNC_STAGES-1];

    assign ir       = ir_q;
    assign jmp      = (ir_q[7:4] == JMP_OPC);
    assign jmp_nz   = (ir_q[7:4] == JNZ_OPC);
    assign jmp_addr = (jmp | jmp_nz) ? ir_q[3:0] : 4'h0;
    // Forward a same-cycle ALU zero result so a JNZ right after the ALU op sees it.
    assign dont_jmp = alu_wr ? alu_zero : z_q;
    assign taken    = jmp | (jmp_nz & ~dont_jmp);
    assign jmp_count = cnt_q;

    always_comb begin
        ir_d  = ir_q;
        z_d   = z_q;
        cnt_d = cnt_q;
        if (sync_reset) begin
            ir_d  = NOP_WORD;
            z_d   = 1'b0;
            cnt_d = '0;
        end else begin
            if (alu_wr) begin
                z_d = alu_zero;
            end
            // A taken jump squashes the shadow word already fetched behind it.
            ir_d = taken ? NOP_WORD : pm_data;
            if (taken && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_q  <= NOP_WORD;
            z_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            ir_q  <= ir_d;
            z_q   <= z_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_instruction_decoder.sv
// Directed bench for instruction_decoder; a second narrow-counter instance shares the
// stimulus so counter saturation is reachable in a few cycles.
module tb_instruction_decoder;

    logic        clk;
    logic        reset_n;
    logic [7:0]  pm_data;
    logic        alu_wr;
    logic        alu_zero;
    logic        sync_reset;
    logic [7:0]  ir;
    logic        jmp;
    logic        jmp_nz;
    logic        dont_jmp;
    logic [3:0]  jmp_addr;
    logic [15:0] jmp_count;

    logic        s_sync_reset;
    logic [7:0]  s_ir;
    logic        s_jmp;
    logic        s_jmp_nz;
    logic        s_dont_jmp;
    logic [3:0]  s_jmp_addr;
    logic [2:0]  s_jmp_count;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt;

    instruction_decoder dut (
        .clk(clk), .reset_n(reset_n), .pm_data(pm_data), .alu_wr(alu_wr),
        .alu_zero(alu_zero), .sync_reset(sync_reset), .ir(ir), .jmp(jmp),
        .jmp_nz(jmp_nz), .dont_jmp(dont_jmp), .jmp_addr(jmp_addr), .jmp_count(jmp_count)
    );

    instruction_decoder #(.CNT_W(3)) dut_s (
        .clk(clk), .reset_n(reset_n), .pm_data(pm_data), .alu_wr(alu_wr),
        .alu_zero(alu_zero), .sync_reset(s_sync_reset), .ir(s_ir), .jmp(s_jmp),
        .jmp_nz(s_jmp_nz), .dont_jmp(s_dont_jmp), .jmp_addr(s_jmp_addr),
        .jmp_count(s_jmp_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n  = 1'b1;
        pm_data  = 8'h00;
        alu_wr   = 1'b0;
        alu_zero = 1'b0;

        // Reset asserted between edges takes effect immediately.
        #2 reset_n = 1'b0;
        #1;
        check("rst_sync_reset", sync_reset, 1);
        check("rst_ir", ir, 8'h00);
        check("rst_jmp", jmp, 0);
        check("rst_jmp_nz", jmp_nz, 0);
        check("rst_jmp_addr", jmp_addr, 0);
        check("rst_dont_jmp", dont_jmp, 0);
        check("rst_count", jmp_count, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check("rel_edge1_sync", sync_reset, 1);
        tick();
        check("rel_edge2_sync", sync_reset, 0);
        check("rel_edge2_ir", ir, 8'h00);

        // Unconditional jump and shadow squash.
        pm_data = 8'hE5;
        tick();
        check("jmp_ir", ir, 8'hE5);
        check("jmp_jmp", jmp, 1);
        check("jmp_jmp_nz", jmp_nz, 0);
        check("jmp_addr5", jmp_addr, 4'h5);
        pm_data = 8'h12;
        tick();
        check("jmp_squash_ir", ir, 8'h00);
        check("jmp_squash_jmp", jmp, 0);
        check("jmp_count1", jmp_count, 1);

        // JNZ not taken when zero flag set.
        alu_wr   = 1'b1;
        alu_zero = 1'b1;
        pm_data  = 8'hF3;
        tick();
        alu_wr  = 1'b0;
        pm_data = 8'h21;
        #1;
        check("jnz_ir", ir, 8'hF3);
        check("jnz_jmp_nz", jmp_nz, 1);
        check("jnz_dont_jmp", dont_jmp, 1);
        check("jnz_addr3", jmp_addr, 4'h3);
        tick();
        check("jnz_fall_ir", ir, 8'h21);
        check("jnz_fall_count", jmp_count, 1);
        check("nonjmp_addr0", jmp_addr, 4'h0);

        // Forwarded alu_zero overrides the stored zero flag.
        pm_data = 8'hF7;
        tick();
        check("fwd_ir", ir, 8'hF7);
        check("fwd_zflag_held", dont_jmp, 1);
        alu_wr   = 1'b1;
        alu_zero = 1'b0;
        pm_data  = 8'h33;
        #1;
        check("fwd_dont_jmp", dont_jmp, 0);
        check("fwd_addr7", jmp_addr, 4'h7);
        tick();
        alu_wr = 1'b0;
        #1;
        check("fwd_squash_ir", ir, 8'h00);
        check("fwd_zflag_cleared", dont_jmp, 0);
        check("fwd_count2", jmp_count, 2);

        // Back-to-back jump words: the second is squashed.
        pm_data = 8'hE1;
        tick();
        check("b2b_jmp", jmp, 1);
        check("b2b_addr1", jmp_addr, 4'h1);
        pm_data = 8'hE2;
        tick();
        check("b2b_squash_ir", ir, 8'h00);
        check("b2b_count3", jmp_count, 3);
        exp_cnt = 3;

        // Drive the narrow counter into saturation; the wide one keeps counting.
        for (int i = 0; i < 6; i++) begin
            pm_data = 8'hE0;
            tick();
            check("sat_jmp", jmp, 1);
            pm_data = 8'h00;
            tick();
            exp_cnt++;
            check("sat_wide_count", jmp_count, exp_cnt);
            check("sat_narrow_count", s_jmp_count, (exp_cnt > 7) ? 7 : exp_cnt);
        end
        check("sat_narrow_hold", s_jmp_count, 3'h7);
        check("sat_wide_count9", jmp_count, 9);

        // Reset in the middle of a jump.
        pm_data = 8'hE2;
        tick();
        check("rmid_jmp", jmp, 1);
        #2 reset_n = 1'b0;
        #1;
        check("rmid_ir", ir, 8'h00);
        check("rmid_jmp", jmp, 0);
        check("rmid_count", jmp_count, 0);
        check("rmid_narrow_count", s_jmp_count, 0);
        check("rmid_sync_reset", sync_reset, 1);
        check("rmid_addr", jmp_addr, 0);
        tick();
        reset_n  = 1'b1;
        alu_wr   = 1'b1;
        alu_zero = 1'b1;
        tick();
        check("rmid_edge1_sync", sync_reset, 1);
        check("rmid_edge1_ir", ir, 8'h00);
        tick();
        alu_wr = 1'b0;
        #1;
        check("rmid_edge2_sync", sync_reset, 0);
        check("rmid_edge2_ir", ir, 8'h00);
        check("rmid_zflag_held", dont_jmp, 0);
        check("rmid_edge2_count", jmp_count, 0);
        tick();
        check("rmid_first_ir", ir, 8'hE2);
        check("rmid_first_jmp", jmp, 1);
        pm_data = 8'h00;
        tick();
        check("rmid_count1", jmp_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
